// File: rtl/rpn_seq_num_bram_arbiter.sv
// rtl/rpn_seq_num_bram_arbiter.sv - round-robin arbiter/sequencer for the single-port sequence number BRAM
//
// Purpose: serialises READ / WRITE / INCR requests from two requesters onto one
// single-port BRAM. Exactly one operation is in flight, so INCR (read, then
// write back old+1) is atomic with respect to the other requester.
//
// Ports:
//   i_clk, i_ap_rst_n             clock, asynchronous active-low reset
//   reqN_valid/ready/op/addr/wdata request channel N (op: 0 READ, 1 WRITE, 2 INCR, 3 READ)
//   rspN_valid/rdata               one-cycle completion pulse, old word (0 for WRITE)
//   to_sequence_number_BRAM_*      BRAM port (CLK, RST, EN, WEN, DIN, ADDR out; DOUT in)
//
// Optional feature macro: RPN_SEQ_NUM_ARB_INCR_EN
//   defined   : op 2 performs the atomic increment write-back
//   undefined : op 2 executes as READ and the incrementer is not built
module rpn_seq_num_bram_arbiter #(
  parameter int BRAM_ADDR_WIDTH           = 32,
  parameter int WAN_SEQUENCE_NUMBER_WIDTH = 32,
  parameter int BRAM_WEN_WIDTH            = 4,
  parameter int READ_LATENCY              = 1
) (
  input  logic                                 i_clk,
  input  logic                                 i_ap_rst_n,
  input  logic                                 req0_valid,
  output logic                                 req0_ready,
  input  logic [1:0]                           req0_op,
  input  logic [BRAM_ADDR_WIDTH-1:0]           req0_addr,
  input  logic [WAN_SEQUENCE_NUMBER_WIDTH-1:0] req0_wdata,
  output logic                                 rsp0_valid,
  output logic [WAN_SEQUENCE_NUMBER_WIDTH-1:0] rsp0_rdata,
  input  logic                                 req1_valid,
  output logic                                 req1_ready,
  input  logic [1:0]                           req1_op,
  input  logic [BRAM_ADDR_WIDTH-1:0]           req1_addr,
  input  logic [WAN_SEQUENCE_NUMBER_WIDTH-1:0] req1_wdata,
  output logic                                 rsp1_valid,
  output logic [WAN_SEQUENCE_NUMBER_WIDTH-1:0] rsp1_rdata,
  output logic                                 to_sequence_number_BRAM_CLK,
  output logic                                 to_sequence_number_BRAM_RST,
  output logic                                 to_sequence_number_BRAM_EN,
  output logic [BRAM_WEN_WIDTH-1:0]            to_sequence_number_BRAM_WEN,
  output logic [WAN_SEQUENCE_NUMBER_WIDTH-1:0] to_sequence_number_BRAM_DIN,
  output logic [BRAM_ADDR_WIDTH-1:0]           to_sequence_number_BRAM_ADDR,
  input  logic [WAN_SEQUENCE_NUMBER_WIDTH-1:0] to_sequence_number_BRAM_DOUT
);

  localparam int W = WAN_SEQUENCE_NUMBER_WIDTH;
  localparam logic [1:0] OP_WRITE = 2'd1;
`ifdef RPN_SEQ_NUM_ARB_INCR_EN
  localparam logic [1:0] OP_INCR  = 2'd2;
`endif
  // RD_WAIT spends READ_LATENCY cycles; the counter value on its last cycle.
  localparam logic WAIT_LAST = (READ_LATENCY == 2);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RD_WAIT, S_COMPLETE} state_t;

  state_t                     state_q, state_d;
  logic                       last_q, last_d;     // last served port
  logic                       port_q, port_d;     // port of the op in flight
  logic                       wr_q, wr_d;         // op in flight is WRITE
  logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [W-1:0]               wdata_q, wdata_d;
  logic [W-1:0]               cap_q, cap_d;       // captured DOUT
  logic [W-1:0]               din_q, din_d;       // DIN holds its last driven value
  logic                       wait_q, wait_d;
`ifdef RPN_SEQ_NUM_ARB_INCR_EN
  logic                       incr_q, incr_d;
`endif

  logic       grant;
  logic [1:0] sel_op;
  logic [W-1:0] rsp_data;

  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      port_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cap_q   <= '0;
      din_q   <= '0;
      wait_q  <= 1'b0;
`ifdef RPN_SEQ_NUM_ARB_INCR_EN
      incr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      port_q  <= port_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cap_q   <= cap_d;
      din_q   <= din_d;
      wait_q  <= wait_d;
`ifdef RPN_SEQ_NUM_ARB_INCR_EN
      incr_q  <= incr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    port_d  = port_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cap_d   = cap_q;
    wait_d  = wait_q;
`ifdef RPN_SEQ_NUM_ARB_INCR_EN
    incr_d  = incr_q;
`endif
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp0_rdata = '0;
    rsp1_rdata = '0;
    to_sequence_number_BRAM_EN  = 1'b0;
    to_sequence_number_BRAM_WEN = '0;
    to_sequence_number_BRAM_DIN = din_q;
    rsp_data = wr_q ? '0 : cap_q;
    // Tie goes to the port not served last; a lone request always wins.
    grant  = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    sel_op = grant ? req1_op : req0_op;

    case (state_q)
      S_IDLE: begin
        req0_ready = req0_valid & ~grant;
        req1_ready = req1_valid & grant;
        if (req0_valid || req1_valid) begin
          port_d  = grant;
          last_d  = grant;
          wr_d    = (sel_op == OP_WRITE);
`ifdef RPN_SEQ_NUM_ARB_INCR_EN
          incr_d  = (sel_op == OP_INCR);
`endif
          addr_d  = grant ? req1_addr : req0_addr;
          wdata_d = grant ? req1_wdata : req0_wdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        to_sequence_number_BRAM_EN = 1'b1;
        if (wr_q) begin
          to_sequence_number_BRAM_WEN = '1;
          to_sequence_number_BRAM_DIN = wdata_q;
          state_d = S_COMPLETE;
        end else begin
          wait_d  = 1'b0;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          cap_d   = to_sequence_number_BRAM_DOUT;
          state_d = S_COMPLETE;
        end else begin
          wait_d = 1'b1;
        end
      end
      S_COMPLETE: begin
        rsp0_valid = ~port_q;
        rsp1_valid = port_q;
        rsp0_rdata = port_q ? '0 : rsp_data;
        rsp1_rdata = port_q ? rsp_data : '0;
`ifdef RPN_SEQ_NUM_ARB_INCR_EN
        // Write-back shares the response cycle so no other op can slip in.
        if (incr_q) begin
          to_sequence_number_BRAM_EN  = 1'b1;
          to_sequence_number_BRAM_WEN = '1;
          to_sequence_number_BRAM_DIN = cap_q + {{(W-1){1'b0}}, 1'b1};
        end
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    din_d = to_sequence_number_BRAM_DIN;
  end

  assign to_sequence_number_BRAM_CLK  = i_clk;
  assign to_sequence_number_BRAM_RST  = ~i_ap_rst_n;
  assign to_sequence_number_BRAM_ADDR = addr_q;

endmodule
